// File: rtl/load_store_buffer.sv
// load_store_buffer: in-order load/store queue feeding the memory controller and LS CDB.
// Optional LSB_MMIO_EN holds IO-space loads (addr[17:16]==2'b11) until they reach the ROB head.
module load_store_buffer #(
   parameter int LSB_BITS = 3,
   parameter int LSB_SIZE = 1 << LSB_BITS
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        i_clear,
   input  logic        i_issue_ready,
   input  logic [4:0]  i_issue_type,
   input  logic [4:0]  i_issue_rob_id,
   output logic        o_lsb_full,
   input  logic        i_cdb_ready,
   input  logic [4:0]  i_cdb_rob_id,
   input  logic [31:0] i_cdb_value,
   input  logic        i_lsb_rs_ready,
   input  logic [4:0]  i_lsb_rob_id,
   input  logic [31:0] i_lsb_st_value,
   input  logic        i_rob_msg_ready,
   input  logic [4:0]  i_rob_msg_id,
`ifdef LSB_MMIO_EN
   input  logic [4:0]  i_rob_head_id,
`endif
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [1:0]  o_mem_size,
   output logic [31:0] o_mem_wdata,
   input  logic        i_mem_done,
   input  logic [31:0] i_mem_rdata,
   output logic        o_cdb_ls_ready,
   output logic [4:0]  o_cdb_ls_rob_id,
   output logic [31:0] o_cdb_ls_value
);
   typedef enum logic {IDLE, WAIT} state_t;
   localparam logic [LSB_BITS:0] W_SIZE = (LSB_BITS+1)'(LSB_SIZE);
   logic [LSB_SIZE-1:0] r_valid, r_addr_rdy, r_data_rdy, r_comm;
   logic [4:0]          r_type [LSB_SIZE];
   logic [4:0]          r_rob  [LSB_SIZE];
   logic [31:0]         r_addr [LSB_SIZE];
   logic [31:0]         r_data [LSB_SIZE];
   logic [LSB_BITS-1:0] r_head, r_tail;
   logic [LSB_BITS:0]   r_count;
   state_t              r_state;
   logic                r_flushed, r_ld_uns;
   logic [4:0]          r_ld_rob;
   logic                w_push, w_done, w_pop, w_start, w_mmio_ok, w_head_load, w_run;
   logic [LSB_SIZE-1:0] w_keep, w_live, w_new;
   logic [4:0]          w_rob [LSB_SIZE];
   logic [LSB_BITS:0]   w_ncomm;
   logic [LSB_BITS-1:0] w_idx;
   function automatic logic [31:0] f_ext(input logic [1:0] sz, input logic uns, input logic [31:0] d);
      return sz == 2'd0 ? {{24{!uns && d[7]}}, d[7:0]} :
             sz == 2'd1 ? {{16{!uns && d[15]}}, d[15:0]} : d;
   endfunction
   assign o_lsb_full  = r_count >= W_SIZE - 1'b1;
   assign w_push      = i_issue_ready && !i_clear && r_count != W_SIZE;
   assign w_head_load = r_type[r_head][4:3] == 2'b00;
`ifdef LSB_MMIO_EN
   assign w_mmio_ok   = r_addr[r_head][17:16] != 2'b11 || i_rob_head_id == r_rob[r_head];
`else
   assign w_mmio_ok   = 1'b1;
`endif
   // a load about to be flushed must not start; committed stores survive the flush
   assign w_start = r_state == IDLE && r_valid[r_head] && r_addr_rdy[r_head] &&
                    (w_head_load ? w_mmio_ok && !i_clear : r_data_rdy[r_head] && r_comm[r_head]);
   assign w_done  = r_state == WAIT && i_mem_done;
   assign w_pop   = w_done && (o_mem_we || (!r_flushed && !i_clear));
   always_comb begin
      w_keep  = '0;
      w_ncomm = '0;
      w_run   = 1'b1;
      w_idx   = '0;
      for (int i = 0; i < LSB_SIZE; i++) begin
         w_idx         = r_head + LSB_BITS'(i);
         w_run         = w_run && r_valid[w_idx] && r_comm[w_idx];
         w_keep[w_idx] = w_run;
         w_ncomm       = w_ncomm + (LSB_BITS+1)'(w_run);
      end
      for (int i = 0; i < LSB_SIZE; i++) begin
         w_new[i]  = w_push && r_tail == LSB_BITS'(i);
         w_live[i] = r_valid[i] || w_new[i];
         w_rob[i]  = w_new[i] ? i_issue_rob_id : r_rob[i];
      end
   end
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_valid    <= '0;
         r_addr_rdy <= '0;
         r_data_rdy <= '0;
         r_comm     <= '0;
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
      end else if (rdy_in) begin
         for (int i = 0; i < LSB_SIZE; i++) begin
            if (w_new[i]) begin
               r_valid[i]    <= 1'b1;
               r_type[i]     <= i_issue_type;
               r_rob[i]      <= i_issue_rob_id;
               r_addr_rdy[i] <= 1'b0;
               r_data_rdy[i] <= 1'b0;
               r_comm[i]     <= 1'b0;
            end
            if (w_live[i] && i_cdb_ready && w_rob[i] == i_cdb_rob_id) begin
               r_addr[i]     <= i_cdb_value;
               r_addr_rdy[i] <= 1'b1;
            end
            if (w_live[i] && i_lsb_rs_ready && w_rob[i] == i_lsb_rob_id) begin
               r_data[i]     <= i_lsb_st_value;
               r_data_rdy[i] <= 1'b1;
            end
            if (w_live[i] && i_rob_msg_ready && w_rob[i] == i_rob_msg_id)
               r_comm[i] <= 1'b1;
            if ((i_clear && !w_keep[i]) || (w_pop && r_head == LSB_BITS'(i)))
               r_valid[i] <= 1'b0;
         end
         r_head  <= r_head + LSB_BITS'(w_pop);
         r_tail  <= i_clear ? r_head + w_ncomm[LSB_BITS-1:0] : r_tail + LSB_BITS'(w_push);
         r_count <= (i_clear ? w_ncomm : r_count + (LSB_BITS+1)'(w_push)) - (LSB_BITS+1)'(w_pop);
      end
   end
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state         <= IDLE;
         r_flushed       <= 1'b0;
         r_ld_uns        <= 1'b0;
         r_ld_rob        <= '0;
         o_mem_req       <= 1'b0;
         o_mem_we        <= 1'b0;
         o_mem_addr      <= '0;
         o_mem_size      <= '0;
         o_mem_wdata     <= '0;
         o_cdb_ls_ready  <= 1'b0;
         o_cdb_ls_rob_id <= '0;
         o_cdb_ls_value  <= '0;
      end else if (rdy_in) begin
         o_cdb_ls_ready <= 1'b0;
         if (w_start) begin
            r_state     <= WAIT;
            o_mem_req   <= 1'b1;
            o_mem_we    <= !w_head_load;
            o_mem_addr  <= r_addr[r_head];
            o_mem_size  <= r_type[r_head][1:0];
            o_mem_wdata <= w_head_load ? '0 : r_data[r_head];
            r_ld_uns    <= r_type[r_head][2];
            r_ld_rob    <= r_rob[r_head];
         end else if (w_done) begin
            r_state         <= IDLE;
            o_mem_req       <= 1'b0;
            r_flushed       <= 1'b0;
            o_cdb_ls_ready  <= !o_mem_we && !r_flushed && !i_clear;
            o_cdb_ls_rob_id <= r_ld_rob;
            o_cdb_ls_value  <= f_ext(o_mem_size, r_ld_uns, i_mem_rdata);
         end else if (r_state == WAIT && i_clear && !o_mem_we) begin
            r_flushed <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_load_store_buffer.sv
// tb_load_store_buffer: scoreboard bench for load_store_buffer (default build, no MMIO port).
module tb_load_store_buffer;
   logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, i_clear = 1'b0;
   logic        i_issue_ready = 1'b0;
   logic [4:0]  i_issue_type = '0, i_issue_rob_id = '0;
   logic        o_lsb_full;
   logic        i_cdb_ready = 1'b0;
   logic [4:0]  i_cdb_rob_id = '0;
   logic [31:0] i_cdb_value = '0;
   logic        i_lsb_rs_ready = 1'b0;
   logic [4:0]  i_lsb_rob_id = '0;
   logic [31:0] i_lsb_st_value = '0;
   logic        i_rob_msg_ready = 1'b0;
   logic [4:0]  i_rob_msg_id = '0;
   logic        o_mem_req, o_mem_we;
   logic [31:0] o_mem_addr, o_mem_wdata;
   logic [1:0]  o_mem_size;
   logic        i_mem_done = 1'b0;
   logic [31:0] i_mem_rdata = '0;
   logic        o_cdb_ls_ready;
   logic [4:0]  o_cdb_ls_rob_id;
   logic [31:0] o_cdb_ls_value;
   int          n_chk = 0, n_fail = 0, n_req = 0;
   logic [66:0] exp_req [$];
   logic [36:0] exp_cdb [$];
   load_store_buffer dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .i_clear(i_clear),
      .i_issue_ready(i_issue_ready), .i_issue_type(i_issue_type), .i_issue_rob_id(i_issue_rob_id),
      .o_lsb_full(o_lsb_full),
      .i_cdb_ready(i_cdb_ready), .i_cdb_rob_id(i_cdb_rob_id), .i_cdb_value(i_cdb_value),
      .i_lsb_rs_ready(i_lsb_rs_ready), .i_lsb_rob_id(i_lsb_rob_id), .i_lsb_st_value(i_lsb_st_value),
      .i_rob_msg_ready(i_rob_msg_ready), .i_rob_msg_id(i_rob_msg_id),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_size(o_mem_size),
      .o_mem_wdata(o_mem_wdata), .i_mem_done(i_mem_done), .i_mem_rdata(i_mem_rdata),
      .o_cdb_ls_ready(o_cdb_ls_ready), .o_cdb_ls_rob_id(o_cdb_ls_rob_id), .o_cdb_ls_value(o_cdb_ls_value)
   );
   always #5 clk_in = ~clk_in;
   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      case (a)
         32'h100:          return 32'hDEADBEEF;
         32'h110, 32'h114: return 32'h00000080;
         32'h118, 32'h11C: return 32'h00008001;
         default:          return a ^ 32'hA5C3_0000;
      endcase
   endfunction
   task automatic issue(input logic [4:0] t, input logic [4:0] r);
      i_issue_ready = 1'b1; i_issue_type = t; i_issue_rob_id = r;
      @(negedge clk_in);
      i_issue_ready = 1'b0;
   endtask
   task automatic cdb(input logic [4:0] r, input logic [31:0] a);
      i_cdb_ready = 1'b1; i_cdb_rob_id = r; i_cdb_value = a;
      @(negedge clk_in);
      i_cdb_ready = 1'b0;
   endtask
   task automatic st(input logic [4:0] r, input logic [31:0] d);
      i_lsb_rs_ready = 1'b1; i_lsb_rob_id = r; i_lsb_st_value = d;
      @(negedge clk_in);
      i_lsb_rs_ready = 1'b0;
   endtask
   task automatic commit(input logic [4:0] r);
      i_rob_msg_ready = 1'b1; i_rob_msg_id = r;
      @(negedge clk_in);
      i_rob_msg_ready = 1'b0;
   endtask
   task automatic clr();
      i_clear = 1'b1;
      @(negedge clk_in);
      i_clear = 1'b0;
   endtask
   task automatic drain(input string tag);
      int k = 0;
      while (k < 400 && !(exp_req.size() == 0 && exp_cdb.size() == 0 && dut.r_count == 0 && !o_mem_req)) begin
         @(negedge clk_in);
         k++;
      end
      chk({"drain_", tag}, k < 400, 1);
      repeat (3) @(negedge clk_in);
   endtask
   task automatic load(input logic [4:0] t, input logic [4:0] r, input logic [31:0] a, input logic [31:0] v);
      exp_req.push_back({1'b0, t[1:0], a, 32'h0});
      exp_cdb.push_back({r, v});
      issue(t, r);
   endtask
   // memory model: checks each request, holds it a few cycles, then pulses done
   initial forever begin
      @(negedge clk_in);
      if (o_mem_req) begin
         logic [31:0] a;
         a = o_mem_addr;
         n_req++;
         chk("req_q", exp_req.size() > 0, 1);
         if (exp_req.size() > 0)
            chk("req", {o_mem_we, o_mem_size, o_mem_addr, o_mem_we ? o_mem_wdata : 32'h0}, exp_req.pop_front());
         repeat (2) begin
            @(negedge clk_in);
            chk("req_hold", {o_mem_req, o_mem_addr}, {1'b1, a});
         end
         i_mem_rdata = mem_rd(a);
         i_mem_done  = 1'b1;
         @(negedge clk_in);
         i_mem_done  = 1'b0;
         chk("req_drop", o_mem_req, 0);
      end
   end
   initial forever begin
      @(negedge clk_in);
      if (o_cdb_ls_ready) begin
         chk("cdb_q", exp_cdb.size() > 0, 1);
         if (exp_cdb.size() > 0) chk("cdb", {o_cdb_ls_rob_id, o_cdb_ls_value}, exp_cdb.pop_front());
      end
   end
   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      n_fail++;
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $fatal(1, "watchdog");
   end
   initial begin
      int k, b;
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;
      chk("rst_req", o_mem_req, 0);
      chk("rst_full", o_lsb_full, 0);
      chk("rst_cdb", {o_cdb_ls_ready, o_cdb_ls_rob_id, o_cdb_ls_value}, 0);
      chk("rst_mem", {o_mem_we, o_mem_size, o_mem_addr, o_mem_wdata}, 0);
      chk("rst_cnt", dut.r_count, 0);
      load(5'd2, 5'd3, 32'h100, 32'hDEADBEEF);
      cdb(5'd3, 32'h100);
      drain("lw");
      chk("cnt_lw", dut.r_count, 0);
      load(5'd0, 5'd1, 32'h110, 32'hFFFFFF80);
      load(5'd4, 5'd2, 32'h114, 32'h00000080);
      load(5'd1, 5'd8, 32'h118, 32'hFFFF8001);
      load(5'd5, 5'd9, 32'h11C, 32'h00008001);
      cdb(5'd9, 32'h11C);
      cdb(5'd2, 32'h114);
      cdb(5'd1, 32'h110);
      cdb(5'd8, 32'h118);
      drain("ext");
      issue(5'd10, 5'd4);
      cdb(5'd4, 32'h200);
      st(5'd4, 32'h12345678);
      b = n_req;
      repeat (20) @(negedge clk_in);
      chk("sw_hold_nreq", n_req, b);
      chk("sw_hold_req", o_mem_req, 0);
      exp_req.push_back({1'b1, 2'd2, 32'h200, 32'h12345678});
      commit(5'd4);
      drain("sw");
      for (int i = 0; i < 7; i++) begin
         issue(5'd2, 5'(10 + i));
         if (i == 5) chk("full_at6", o_lsb_full, 0);
      end
      chk("full_at7", o_lsb_full, 1);
      chk("cnt_at7", dut.r_count, 7);
      exp_req.push_back({1'b0, 2'd2, 32'h2000, 32'h0});
      exp_cdb.push_back({5'd10, mem_rd(32'h2000)});
      cdb(5'd10, 32'h2000);
      k = 0;
      while (k < 50 && dut.r_count != 6) begin @(negedge clk_in); k++; end
      chk("full_pop", o_lsb_full, 0);
      for (int i = 1; i < 7; i++) begin
         exp_req.push_back({1'b0, 2'd2, 32'h2000 + 32'(4 * i), 32'h0});
         exp_cdb.push_back({5'(10 + i), mem_rd(32'h2000 + 32'(4 * i))});
         cdb(5'(10 + i), 32'h2000 + 32'(4 * i));
      end
      drain("full");
      issue(5'd10, 5'd5);
      issue(5'd2, 5'd6);
      issue(5'd1, 5'd7);
      st(5'd5, 32'hCAFEF00D);
      cdb(5'd6, 32'h400);
      cdb(5'd7, 32'h404);
      commit(5'd5);
      chk("cnt_pre_clr", dut.r_count, 3);
      clr();
      chk("cnt_post_clr", dut.r_count, 1);
      exp_req.push_back({1'b1, 2'd2, 32'h300, 32'hCAFEF00D});
      cdb(5'd5, 32'h300);
      drain("clr_st");
      exp_req.push_back({1'b0, 2'd2, 32'h500, 32'h0});
      issue(5'd2, 5'd9);
      cdb(5'd9, 32'h500);
      k = 0;
      while (k < 20 && !o_mem_req) begin @(negedge clk_in); k++; end
      chk("inflight_req", o_mem_req, 1);
      clr();
      chk("cnt_inflight_clr", dut.r_count, 0);
      drain("clr_ld");
      for (int i = 0; i < 20; i++) begin
         k = 0;
         while (k < 200 && o_lsb_full) begin @(negedge clk_in); k++; end
         load(5'd2, 5'(i), 32'h1000 + 32'(4 * i), mem_rd(32'h1000 + 32'(4 * i)));
         cdb(5'(i), 32'h1000 + 32'(4 * i));
      end
      drain("wrap");
      chk("wrap_ptr", {dut.r_head, dut.r_tail}, {dut.r_tail, dut.r_tail} & 6'h3F);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/load_store_buffer.md
Name: load_store_buffer

Overview:
- In-order memory queue on the consumer side of the load/store reservation station.
- Holds every load/store in program order. Captures the effective address from the ALU CDB and the store data from the LS reservation station.
- Executes the head entry against the memory controller: loads when the address is known, stores once the ROB commits them.
- Broadcasts load results on the LS CDB channel.

Parameters:
- LSB_BITS, 3, log2 of queue depth
- LSB_SIZE, 8, queue depth (1<<LSB_BITS)

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  pause when low; no state changes
- _clear  input  1  mispredict flush
- _issue_ready  input  1  allocate entry at tail
- _issue_type  input  5  0=LB 1=LH 2=LW 4=LBU 5=LHU 8=SB 9=SH 10=SW
- _issue_rob_id  input  5  ROB tag of instruction
- _lsb_full  output  1  no room for next issue
- _cdb_ready  input  1  ALU CDB valid (carries effective address)
- _cdb_rob_id  input  5  tag on ALU CDB
- _cdb_value  input  32  effective address
- _lsb_rs_ready  input  1  store data valid from RS
- _lsb_rob_id  input  5  tag of that store
- _lsb_st_value  input  32  store data
- _rob_msg_ready  input  1  ROB commits a store
- _rob_msg_id  input  5  tag of committed store
- _mem_req  output  1  memory request, held until _mem_done
- _mem_we  output  1  1=store
- _mem_addr  output  32  byte address
- _mem_size  output  2  0=byte 1=half 2=word
- _mem_wdata  output  32  store data, low bytes significant
- _mem_done  input  1  one-cycle completion pulse
- _mem_rdata  input  32  raw load data, valid with _mem_done
- _cdb_ls_ready  output  1  load result valid, one-cycle pulse
- _cdb_ls_rob_id  output  5  tag of load result
- _cdb_ls_value  output  32  extended load result

Behaviour:
- Reset values: all outputs 0; head=tail=count=0; all entries invalid; FSM=IDLE.
- Circular queue. Per entry: valid, type, rob_id, addr, addr_rdy, data, data_rdy, committed. Head/tail wrap modulo LSB_SIZE.
- _lsb_full = (count >= LSB_SIZE-1), combinational. The spare slot covers a one-cycle issue latency. Issue while count==LSB_SIZE is ignored.
- Issue: write entry at tail with address, data and committed flags cleared; tail+1 next cycle.
- Operand capture:
  - Every valid entry compares its rob_id against _cdb_rob_id, _lsb_rob_id and _rob_msg_id in parallel.
  - A match sets addr, data or committed respectively.
  - A match on an entry issued in the same cycle is also captured.
- FSM IDLE:
  - Head load with addr_rdy: assert _mem_req/_mem_size/_mem_addr next cycle, we=0, go to WAIT.
  - Head store with addr_rdy, data_rdy and committed: same, with we=1 and wdata; go to WAIT.
- FSM WAIT:
  - Request outputs held stable until _mem_done.
  - On _mem_done: drop _mem_req; pop head (head+1, count-1); return to IDLE.
  - For a load, pulse _cdb_ls_ready with the rob_id and extended value the same cycle.
  - Next request issues no earlier than the cycle after _mem_done.
- Extension:
  - LB/LH: sign-extend bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: pass through.
- Push and pop in the same cycle: count unchanged.
- _clear:
  - Entries with committed=1 are preserved (always a contiguous prefix from head). All others are invalidated; tail=head+number committed.
  - An in-flight store continues.
  - An in-flight load keeps WAIT until _mem_done, pops nothing, and emits no CDB broadcast.
  - _clear has priority over issue in the same cycle.
- rdy_in low: every register holds, including _cdb_ls_ready.

Optional Feature:
- LSB_MMIO_EN defined:
  - Adds input _rob_head_id (5 bits).
  - A head load with addr[17:16]==2'b11 issues only when _rob_head_id equals its rob_id (non-speculative IO read).
- LSB_MMIO_EN undefined: the port is absent and all loads issue as soon as addr_rdy.

Test Plan:
- Issue LW tag 3; CDB addr 0x100 tag 3; mem returns 0xDEADBEEF -> _mem_req with addr 0x100, size 2; then _cdb_ls_ready, tag 3, value 0xDEADBEEF; count 0.
- LB tag 1, rdata 0x00000080 -> value 0xFFFFFF80. LBU tag 2 same data -> 0x00000080.
- SW tag 4, addr 0x200, data 0x12345678, no commit -> no _mem_req for 20 cycles; commit tag 4 -> _mem_req we=1 wdata 0x12345678; no CDB pulse.
- Issue 7 entries -> _lsb_full=1 at count 7; pop one -> _lsb_full=0.
- Committed SW tag 5 then LW tag 6 and LH tag 7 queued; _clear -> store still executes; count becomes 0 after it completes; no CDB pulses for tags 6 or 7.
- Tail wrap: 20 sequential LW, tags 0..19 mod 32 -> results in order, head/tail wrap without loss.
